overload_detector: RTL and testbench
====================================

Name: overload_detector

Overview:
- Monitors the quantized VGA output (`amplified_signal`) and decides whether the current gain clips the ADC.
- Drives the `overload` input of the agc block, closing the gain loop that agc opens with `vga_control` / `gain_array_out`.
- Counts clipped samples over a fixed window and reports once per window.
- Blanks its input for a settle period after every gain change, so it never judges samples taken at a stale gain.

Parameters:
- SIG_W, 4, sample width; offset-binary ADC code.
- WINDOW, 16, accepted samples per evaluation window (>=2).
- HIT_COUNT, 2, clipped samples in a window at or above which overload is declared (1..WINDOW).
- SETTLE, 4, clock cycles of input blanking after enable or gain_change (0 allowed).
- CW, $clog2(WINDOW+1), width of the clip counter and of clip_count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- enable  input  1  level; detector runs while high.
- sample_valid  input  1  amplified_signal is valid this cycle.
- amplified_signal  input  SIG_W  ADC sample from the VGA chain.
- gain_change  input  1  one-cycle pulse from agc whenever it updates gain_array_out.
- overload  output  1  registered verdict of the last completed window; feeds agc.
- result_valid  output  1  high while overload reflects a window taken at the current gain.
- window_done  output  1  one-cycle pulse when a window verdict is published.
- clip_count  output  CW  clip count of the last completed window.

Behaviour:
- Reset: state IDLE; all internal counters 0; overload=0, result_valid=0, window_done=0, clip_count=0. RESET overrides every other input.
- Clip definition: a sample is clipped when amplified_signal == 0 or amplified_signal == 2^SIG_W-1.
- FSM states: IDLE, SETTLE, ACCUM.
- IDLE:
  - sample_valid is ignored.
  - When enable=1, go to SETTLE with settle counter = SETTLE. If SETTLE=0, go directly to ACCUM.
- SETTLE:
  - Lasts exactly SETTLE cycles; sample_valid is ignored.
  - Then go to ACCUM with sample counter and clip counter = 0.
- ACCUM, on each cycle with sample_valid=1:
  - Sample counter +1.
  - Clip counter +1 if the sample is clipped.
- Publishing a verdict: on the clock edge that accepts the WINDOW-th sample (that sample included):
  - overload <= (clips >= HIT_COUNT).
  - clip_count <= clips.
  - result_valid <= 1.
  - window_done = 1 for one cycle.
  - Both counters clear; stay in ACCUM. The next window begins on the next accepted sample with no gap.
- overload and clip_count change only at a publish, on enable going low, or on RESET.
- gain_change=1 in SETTLE or ACCUM:
  - Abort the current window; counters clear.
  - result_valid <= 0; overload holds its value.
  - Go to SETTLE (or to ACCUM if SETTLE=0).
  - gain_change in IDLE is ignored.
- Simultaneous events:
  - gain_change on the same cycle as the WINDOW-th sample: gain_change wins. No publish, no window_done.
  - enable=0 beats gain_change.
- enable=0 in any state: next cycle IDLE; counters clear; overload=0, result_valid=0, clip_count=0; window_done is not pulsed.
- Counter rules: no wrap. The sample counter never exceeds WINDOW-1 before clearing, and the clip counter is bounded by WINDOW.
- Latency: window_done and the new overload are visible the cycle after the last sample is accepted. With continuous sample_valid, the first publish occurs 1+SETTLE+WINDOW edges after enable is first sampled high.

Test Plan:
- RESET high 2 cycles mid-activity -> overload=0, result_valid=0, window_done=0, clip_count=0 next cycle; no window_done until a full settle plus window completes.
- enable=1, sample_valid=1 continuous, samples=8 -> first window_done 21 cycles after enable is sampled high, overload=0, clip_count=0, result_valid=1; further pulses every 16 cycles.
- Window containing one 15 and fourteen 8s plus a final 8 -> overload=0, clip_count=1. Next window with one 0 and one 15 -> overload=1, clip_count=2. Following window with all 8s -> overload returns to 0.
- sample_valid toggling every other cycle, with a sample of 15 presented on the invalid cycles -> window_done every 32 cycles, clip_count=0 (invalid samples are not counted).
- Overload window published (overload=1), then gain_change pulse after 10 samples containing 3 clips -> result_valid=0 next cycle, overload stays 1, no window_done. Next publish comes 4 cycles settle + 16 samples later, with a clip count excluding the 3 pre-change clips.
- gain_change coincident with the 16th sample -> no window_done, clip_count unchanged. Separately, enable dropped mid-window -> overload=0, result_valid=0, state IDLE next cycle.

Source files
------------

// File: rtl/overload_detector.sv
// Counts clipped ADC samples over fixed windows and publishes an overload verdict per window.
// Input is blanked for a settle period after enable or a gain change so stale-gain samples are never judged.
module overload_detector #(
    parameter int SIG_W     = 4,
    parameter int WINDOW    = 16,
    parameter int HIT_COUNT = 2,
    parameter int SETTLE    = 4,
    parameter int CW        = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [SIG_W-1:0] amplified_signal,
    input  logic             gain_change,
    output logic             overload,
    output logic             result_valid,
    output logic             window_done,
    output logic [CW-1:0]    clip_count
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(WINDOW - 1);
    localparam logic [CW-1:0] HIT_THRESH  = CW'(HIT_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM
    } state_t;

    // With no settle time the blanking state is skipped entirely.
    localparam state_t RESTART_STATE = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;

    state_t          r_state;
    logic [SW-1:0]   r_settleCnt;
    logic [CW-1:0]   r_sampleCnt;
    logic [CW-1:0]   r_clipCnt;
    logic            r_overload;
    logic            r_resultValid;
    logic            r_windowDone;
    logic [CW-1:0]   r_clipCountOut;

    state_t          w_nextState;
    logic [SW-1:0]   w_nextSettleCnt;
    logic [CW-1:0]   w_nextSampleCnt;
    logic [CW-1:0]   w_nextClipCnt;
    logic            w_nextOverload;
    logic            w_nextResultValid;
    logic            w_nextWindowDone;
    logic [CW-1:0]   w_nextClipCountOut;

    logic            w_isClip;
    logic [CW-1:0]   w_clipSum;

    assign w_isClip  = (amplified_signal == '0) || (amplified_signal == '1);
    assign w_clipSum = r_clipCnt + CW'(w_isClip);

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_settleCnt    <= '0;
            r_sampleCnt    <= '0;
            r_clipCnt      <= '0;
            r_overload     <= 1'b0;
            r_resultValid  <= 1'b0;
            r_windowDone   <= 1'b0;
            r_clipCountOut <= '0;
        end else begin
            r_state        <= w_nextState;
            r_settleCnt    <= w_nextSettleCnt;
            r_sampleCnt    <= w_nextSampleCnt;
            r_clipCnt      <= w_nextClipCnt;
            r_overload     <= w_nextOverload;
            r_resultValid  <= w_nextResultValid;
            r_windowDone   <= w_nextWindowDone;
            r_clipCountOut <= w_nextClipCountOut;
        end
    end

    // Priority: enable low, then gain change, then sample accumulation.
    always_comb begin
        w_nextState        = r_state;
        w_nextSettleCnt    = r_settleCnt;
        w_nextSampleCnt    = r_sampleCnt;
        w_nextClipCnt      = r_clipCnt;
        w_nextOverload     = r_overload;
        w_nextResultValid  = r_resultValid;
        w_nextWindowDone   = 1'b0;
        w_nextClipCountOut = r_clipCountOut;

        if (!enable) begin
            w_nextState        = ST_IDLE;
            w_nextSettleCnt    = '0;
            w_nextSampleCnt    = '0;
            w_nextClipCnt      = '0;
            w_nextOverload     = 1'b0;
            w_nextResultValid  = 1'b0;
            w_nextClipCountOut = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextState     = RESTART_STATE;
                    w_nextSettleCnt = SETTLE_INIT;
                    w_nextSampleCnt = '0;
                    w_nextClipCnt   = '0;
                end
                ST_SETTLE: begin
                    w_nextSampleCnt = '0;
                    w_nextClipCnt   = '0;
                    if (gain_change) begin
                        w_nextState       = RESTART_STATE;
                        w_nextSettleCnt   = SETTLE_INIT;
                        w_nextResultValid = 1'b0;
                    end else if (r_settleCnt <= SW'(1)) begin
                        w_nextState     = ST_ACCUM;
                        w_nextSettleCnt = '0;
                    end else begin
                        w_nextSettleCnt = r_settleCnt - SW'(1);
                    end
                end
                ST_ACCUM: begin
                    if (gain_change) begin
                        w_nextState       = RESTART_STATE;
                        w_nextSettleCnt   = SETTLE_INIT;
                        w_nextSampleCnt   = '0;
                        w_nextClipCnt     = '0;
                        w_nextResultValid = 1'b0;
                    end else if (sample_valid) begin
                        if (r_sampleCnt == LAST_SAMPLE) begin
                            w_nextOverload     = (w_clipSum >= HIT_THRESH);
                            w_nextClipCountOut = w_clipSum;
                            w_nextResultValid  = 1'b1;
                            w_nextWindowDone   = 1'b1;
                            w_nextSampleCnt    = '0;
                            w_nextClipCnt      = '0;
                        end else begin
                            w_nextSampleCnt = r_sampleCnt + CW'(1);
                            w_nextClipCnt   = w_clipSum;
                        end
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    assign overload     = r_overload;
    assign result_valid = r_resultValid;
    assign window_done  = r_windowDone;
    assign clip_count   = r_clipCountOut;

endmodule

// File: tb/tb_overload_detector.sv
// Directed self-checking bench for overload_detector using its default parameters.
// Inputs are set before a rising edge; outputs are checked 1 time unit after it.
module tb_overload_detector;

    localparam int SIG_W = 4;
    localparam int CW    = 5;

    logic             clk;
    logic             RESET;
    logic             enable;
    logic             sampleValid;
    logic [SIG_W-1:0] ampSignal;
    logic             gainChange;
    logic             overload;
    logic             resultValid;
    logic             windowDone;
    logic [CW-1:0]    clipCount;

    int errCount;
    int checkCount;

    overload_detector dut (
        .clk              (clk),
        .RESET            (RESET),
        .enable           (enable),
        .sample_valid     (sampleValid),
        .amplified_signal (ampSignal),
        .gain_change      (gainChange),
        .overload         (overload),
        .result_valid     (resultValid),
        .window_done      (windowDone),
        .clip_count       (clipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; enable = 1'b0; sampleValid = 1'b0; ampSignal = 4'd8; gainChange = 1'b0;
        step();
        step();
        checkCount += 4;
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL reset_overload got=%b want=0", overload); end
        if (resultValid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_result_valid got=%b want=0", resultValid); end
        if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL reset_window_done got=%b want=0", windowDone); end
        if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL reset_clip_count got=%0d want=0", clipCount); end
        RESET = 1'b0;
    endtask

    // Enable sampled at the first edge; the first verdict lands on the 21st edge.
    task automatic test_first_window();
        enable = 1'b1; sampleValid = 1'b1; ampSignal = 4'd8;
        for (int k = 0; k < 20; k++) begin
            step();
            checkCount++;
            if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL first_early_done edge=%0d got=%b want=0", k, windowDone); end
        end
        step();
        checkCount += 4;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL first_done got=%b want=1", windowDone); end
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL first_overload got=%b want=0", overload); end
        if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL first_clip_count got=%0d want=0", clipCount); end
        if (resultValid !== 1'b1) begin errCount++; $display("[TB] FAIL first_result_valid got=%b want=1", resultValid); end
        for (int k = 0; k < 15; k++) begin
            step();
            checkCount++;
            if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL second_early_done edge=%0d got=%b want=0", k, windowDone); end
        end
        step();
        checkCount++;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL second_done got=%b want=1", windowDone); end
    endtask

    task automatic test_clip_patterns();
        for (int i = 0; i < 16; i++) begin
            ampSignal = (i == 0) ? 4'd15 : 4'd8;
            step();
        end
        checkCount += 3;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL oneclip_done got=%b want=1", windowDone); end
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL oneclip_overload got=%b want=0", overload); end
        if (clipCount !== 5'd1) begin errCount++; $display("[TB] FAIL oneclip_clip_count got=%0d want=1", clipCount); end
        for (int i = 0; i < 16; i++) begin
            ampSignal = (i == 3) ? 4'd0 : ((i == 9) ? 4'd15 : 4'd8);
            step();
        end
        checkCount += 3;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL twoclip_done got=%b want=1", windowDone); end
        if (overload !== 1'b1) begin errCount++; $display("[TB] FAIL twoclip_overload got=%b want=1", overload); end
        if (clipCount !== 5'd2) begin errCount++; $display("[TB] FAIL twoclip_clip_count got=%0d want=2", clipCount); end
        ampSignal = 4'd8;
        for (int i = 0; i < 15; i++) step();
        checkCount++;
        if (overload !== 1'b1) begin errCount++; $display("[TB] FAIL midwindow_overload_hold got=%b want=1", overload); end
        step();
        checkCount += 3;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL noclip_done got=%b want=1", windowDone); end
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL noclip_overload got=%b want=0", overload); end
        if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL noclip_clip_count got=%0d want=0", clipCount); end
    endtask

    // Clipping values on invalid cycles must not be counted.
    task automatic test_sparse_valid();
        logic expDone;
        for (int i = 0; i < 64; i++) begin
            sampleValid = ((i % 2) == 0);
            ampSignal   = ((i % 2) == 0) ? 4'd8 : 4'd15;
            step();
            expDone = (i == 30) || (i == 62);
            checkCount++;
            if (windowDone !== expDone) begin errCount++; $display("[TB] FAIL sparse_done cycle=%0d got=%b want=%b", i, windowDone, expDone); end
            if (expDone) begin
                checkCount++;
                if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL sparse_clip_count cycle=%0d got=%0d want=0", i, clipCount); end
            end
        end
        sampleValid = 1'b1;
    endtask

    task automatic test_gain_change();
        for (int i = 0; i < 16; i++) begin
            ampSignal = (i == 0) ? 4'd0 : ((i == 1) ? 4'd15 : 4'd8);
            step();
        end
        checkCount++;
        if (overload !== 1'b1) begin errCount++; $display("[TB] FAIL gc_pre_overload got=%b want=1", overload); end
        for (int i = 0; i < 10; i++) begin
            ampSignal = ((i % 4) == 0) ? 4'd15 : 4'd8;
            step();
        end
        sampleValid = 1'b0; gainChange = 1'b1;
        step();
        gainChange = 1'b0;
        checkCount += 3;
        if (resultValid !== 1'b0) begin errCount++; $display("[TB] FAIL gc_result_valid got=%b want=0", resultValid); end
        if (overload !== 1'b1) begin errCount++; $display("[TB] FAIL gc_overload_hold got=%b want=1", overload); end
        if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL gc_window_done got=%b want=0", windowDone); end
        sampleValid = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            ampSignal = (k <= 4) ? 4'd15 : ((k == 5) ? 4'd0 : 4'd8);
            step();
            checkCount++;
            if (windowDone !== 1'b0 || resultValid !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL gc_settle_quiet edge=%0d got done=%b rv=%b want done=0 rv=0", k, windowDone, resultValid);
            end
        end
        ampSignal = 4'd8;
        step();
        checkCount += 4;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL gc_post_done got=%b want=1", windowDone); end
        if (clipCount !== 5'd1) begin errCount++; $display("[TB] FAIL gc_post_clip_count got=%0d want=1", clipCount); end
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL gc_post_overload got=%b want=0", overload); end
        if (resultValid !== 1'b1) begin errCount++; $display("[TB] FAIL gc_post_result_valid got=%b want=1", resultValid); end
    endtask

    // Gain change on the 16th sample, then enable dropped mid-window alongside a gain change.
    task automatic test_back_to_back();
        ampSignal = 4'd15;
        for (int i = 0; i < 15; i++) step();
        gainChange = 1'b1;
        step();
        gainChange = 1'b0;
        checkCount += 4;
        if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL coinc_window_done got=%b want=0", windowDone); end
        if (clipCount !== 5'd1) begin errCount++; $display("[TB] FAIL coinc_clip_count got=%0d want=1", clipCount); end
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL coinc_overload got=%b want=0", overload); end
        if (resultValid !== 1'b0) begin errCount++; $display("[TB] FAIL coinc_result_valid got=%b want=0", resultValid); end
        for (int k = 0; k < 20; k++) step();
        checkCount += 3;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL fullclip_done got=%b want=1", windowDone); end
        if (clipCount !== 5'd16) begin errCount++; $display("[TB] FAIL fullclip_clip_count got=%0d want=16", clipCount); end
        if (overload !== 1'b1) begin errCount++; $display("[TB] FAIL fullclip_overload got=%b want=1", overload); end
        ampSignal = 4'd8;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0; gainChange = 1'b1;
        step();
        gainChange = 1'b0;
        checkCount += 4;
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL drop_overload got=%b want=0", overload); end
        if (resultValid !== 1'b0) begin errCount++; $display("[TB] FAIL drop_result_valid got=%b want=0", resultValid); end
        if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL drop_clip_count got=%0d want=0", clipCount); end
        if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL drop_window_done got=%b want=0", windowDone); end
        ampSignal = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkCount++;
            if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL idle_done cycle=%0d got=%b want=0", i, windowDone); end
        end
        enable = 1'b1; ampSignal = 4'd8;
        for (int k = 0; k < 20; k++) begin
            step();
            checkCount++;
            if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL reenable_early_done edge=%0d got=%b want=0", k, windowDone); end
        end
        step();
        checkCount += 2;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL reenable_done got=%b want=1", windowDone); end
        if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL reenable_clip_count got=%0d want=0", clipCount); end
    endtask

    task automatic test_reset_midactivity();
        ampSignal = 4'd15;
        for (int i = 0; i < 16; i++) step();
        checkCount++;
        if (overload !== 1'b1) begin errCount++; $display("[TB] FAIL premid_overload got=%b want=1", overload); end
        for (int i = 0; i < 6; i++) step();
        RESET = 1'b1;
        step();
        checkCount += 4;
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL midreset_overload got=%b want=0", overload); end
        if (resultValid !== 1'b0) begin errCount++; $display("[TB] FAIL midreset_result_valid got=%b want=0", resultValid); end
        if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL midreset_window_done got=%b want=0", windowDone); end
        if (clipCount !== 5'd0) begin errCount++; $display("[TB] FAIL midreset_clip_count got=%0d want=0", clipCount); end
        step();
        RESET = 1'b0; ampSignal = 4'd8;
        for (int k = 0; k < 20; k++) begin
            step();
            checkCount++;
            if (windowDone !== 1'b0) begin errCount++; $display("[TB] FAIL postreset_early_done edge=%0d got=%b want=0", k, windowDone); end
        end
        step();
        checkCount += 3;
        if (windowDone !== 1'b1) begin errCount++; $display("[TB] FAIL postreset_done got=%b want=1", windowDone); end
        if (overload !== 1'b0) begin errCount++; $display("[TB] FAIL postreset_overload got=%b want=0", overload); end
        if (resultValid !== 1'b1) begin errCount++; $display("[TB] FAIL postreset_result_valid got=%b want=1", resultValid); end
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        test_reset();
        test_first_window();
        test_clip_patterns();
        test_sparse_valid();
        test_gain_change();
        test_back_to_back();
        test_reset_midactivity();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
